// File: rtl/fetch_redirect_if.sv
// Request/control bundle between hazard/decode/CP0 logic (master) and the fetch redirect controller (slave).
interface fetch_redirect_if;
  logic        stallReq;
  logic        brReq;
  logic [31:0] brOffset;
  logic        jReq;
  logic [25:0] jIndex;
  logic        jrReq;
  logic [31:0] jrTarget;
  logic        eretReq;
  logic [31:0] epc;
  logic        excReq;

  logic        stall;
  logic        isBranch;
  logic [31:0] branchAddr;
  logic        isJump;
  logic [25:0] jumpAddr;
  logic        isJumpReg;
  logic [31:0] jumpRegAddr;
  logic        flush;
  logic [31:0] redirectCount;

  modport master (
    output stallReq, brReq, brOffset, jReq, jIndex, jrReq, jrTarget, eretReq, epc, excReq,
    input  stall, isBranch, branchAddr, isJump, jumpAddr, isJumpReg, jumpRegAddr, flush, redirectCount
  );

  modport slave (
    input  stallReq, brReq, brOffset, jReq, jIndex, jrReq, jrTarget, eretReq, epc, excReq,
    output stall, isBranch, branchAddr, isJump, jumpAddr, isJumpReg, jumpRegAddr, flush, redirectCount
  );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Turns redirect pulses and hazard stalls into the fetch stage's one-hot control set; zero latency.
// A redirect arriving under stall is held until stallReq drops; exceptions override stall and flush.
module fetch_redirect_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  fetch_redirect_if.slave bus
);

  typedef enum logic [1:0] {RUN, PEND, EXC} state_t;
  typedef enum logic [1:0] {K_BR, K_J, K_JR, K_ERET} kind_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t      state, state_nxt;
  kind_t       pend_kind, pend_kind_nxt;
  logic [31:0] pend_op, pend_op_nxt;
  logic [3:0]  flush_cnt, flush_cnt_nxt;
  logic [31:0] count;

  kind_t       req_kind, iss_kind;
  logic [31:0] req_op, iss_op;
  logic        req_vld, iss_vld, exc_take, stall_c, flush_c;

  // Non-exception request selection; lower-priority pulses are simply dropped.
  always_comb begin
    req_vld  = 1'b1;
    req_kind = K_BR;
    req_op   = '0;
    if (bus.eretReq) begin
      req_kind = K_ERET;
      req_op   = bus.epc;
    end else if (bus.jrReq) begin
      req_kind = K_JR;
      req_op   = bus.jrTarget;
    end else if (bus.jReq) begin
      req_kind = K_J;
      req_op   = {6'b0, bus.jIndex};
    end else if (bus.brReq) begin
      req_kind = K_BR;
      req_op   = bus.brOffset;
    end else begin
      req_vld  = 1'b0;
    end
  end

  always_comb begin
    state_nxt     = state;
    pend_kind_nxt = pend_kind;
    pend_op_nxt   = pend_op;
    flush_cnt_nxt = flush_cnt;
    iss_vld       = 1'b0;
    iss_kind      = K_BR;
    iss_op        = '0;
    exc_take      = 1'b0;
    stall_c       = 1'b0;
    flush_c       = 1'b0;

    if (bus.excReq) begin
      exc_take      = 1'b1;
      pend_kind_nxt = K_BR;
      pend_op_nxt   = '0;
      if (FLUSH_CYCLES > 1) begin
        state_nxt     = EXC;
        flush_cnt_nxt = FLUSH_LOAD;
      end else begin
        state_nxt     = RUN;
        flush_cnt_nxt = '0;
      end
    end else begin
      case (state)
        RUN: begin
          if (bus.stallReq) begin
            stall_c = 1'b1;
            if (req_vld) begin
              pend_kind_nxt = req_kind;
              pend_op_nxt   = req_op;
              state_nxt     = PEND;
            end
          end else if (req_vld) begin
            iss_vld  = 1'b1;
            iss_kind = req_kind;
            iss_op   = req_op;
          end
        end
        PEND: begin
          stall_c = bus.stallReq;
          if (!bus.stallReq) begin
            iss_vld       = 1'b1;
            iss_kind      = pend_kind;
            iss_op        = pend_op;
            pend_kind_nxt = K_BR;
            pend_op_nxt   = '0;
            state_nxt     = RUN;
          end
        end
        EXC: begin
          stall_c = bus.stallReq;
          flush_c = 1'b1;
          if (flush_cnt <= 4'd1) begin
            flush_cnt_nxt = '0;
            state_nxt     = RUN;
          end else begin
            flush_cnt_nxt = flush_cnt - 4'd1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pend_kind <= K_BR;
      pend_op   <= '0;
      flush_cnt <= '0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      pend_kind <= pend_kind_nxt;
      pend_op   <= pend_op_nxt;
      flush_cnt <= flush_cnt_nxt;
      if (iss_vld || exc_take) count <= count + 32'd1;
    end
  end

  // Every output is forced low while reset is asserted.
  assign bus.stall         = !reset && stall_c;
  assign bus.isBranch      = !reset && iss_vld && (iss_kind == K_BR);
  assign bus.branchAddr    = bus.isBranch ? iss_op : '0;
  assign bus.isJump        = !reset && iss_vld && (iss_kind == K_J);
  assign bus.jumpAddr      = bus.isJump ? iss_op[25:0] : '0;
  assign bus.isJumpReg     = !reset && (exc_take || (iss_vld && (iss_kind == K_JR || iss_kind == K_ERET)));
  assign bus.jumpRegAddr   = !bus.isJumpReg ? '0 : (exc_take ? EXC_VECTOR : iss_op);
  assign bus.flush         = !reset && (exc_take || flush_c || (iss_vld && iss_kind == K_ERET));
  assign bus.redirectCount = reset ? '0 : count;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl with a queue-based reference model checked every cycle.
module tb_fetch_redirect_ctrl;
  localparam logic [31:0] EXC_VEC = 32'h0000_4180;
  localparam int          FLUSH_N = 2;
  localparam int K_BR = 0, K_J = 1, K_JR = 2, K_ER = 3;

  typedef struct {
    int          kind;
    logic [31:0] op;
  } pend_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  fetch_redirect_if bus ();

  fetch_redirect_ctrl #(.EXC_VECTOR(EXC_VEC), .FLUSH_CYCLES(FLUSH_N)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending redirects in a queue, remaining flush cycles as a plain integer.
  pend_t       mq[$];
  pend_t       p;
  int          m_flush = 0;
  logic [31:0] m_cnt = 0;
  logic        e_stall, e_br, e_j, e_jr, e_fl, have;
  logic [31:0] e_ba, e_jra, e_cnt, iop;
  logic [25:0] e_ja;
  int          ik;
  bit          issue;

  always @(negedge clk) begin
    e_stall = 0; e_br = 0; e_j = 0; e_jr = 0; e_fl = 0;
    e_ba = 0; e_ja = 0; e_jra = 0;
    issue = 0; have = 0; ik = 0; iop = 0;
    e_cnt = reset ? 32'd0 : m_cnt;
    if (reset) begin
      mq.delete();
      m_flush = 0;
      m_cnt = 0;
    end else if (bus.excReq) begin
      e_jr = 1; e_jra = EXC_VEC; e_fl = 1;
      mq.delete();
      m_cnt = m_cnt + 1;
      m_flush = FLUSH_N - 1;
    end else if (m_flush > 0) begin
      e_fl = 1;
      e_stall = bus.stallReq;
      m_flush--;
    end else if (mq.size() > 0) begin
      e_stall = bus.stallReq;
      if (!bus.stallReq) begin
        p = mq.pop_front();
        issue = 1; ik = p.kind; iop = p.op;
      end
    end else begin
      if (bus.eretReq)    begin have = 1; ik = K_ER; iop = bus.epc; end
      else if (bus.jrReq) begin have = 1; ik = K_JR; iop = bus.jrTarget; end
      else if (bus.jReq)  begin have = 1; ik = K_J;  iop = {6'b0, bus.jIndex}; end
      else if (bus.brReq) begin have = 1; ik = K_BR; iop = bus.brOffset; end
      e_stall = bus.stallReq;
      if (have) begin
        if (bus.stallReq) begin
          p.kind = ik; p.op = iop;
          mq.push_back(p);
        end else begin
          issue = 1;
        end
      end
    end
    if (issue) begin
      m_cnt = m_cnt + 1;
      case (ik)
        K_BR:    begin e_br = 1; e_ba = iop; end
        K_J:     begin e_j = 1; e_ja = iop[25:0]; end
        K_JR:    begin e_jr = 1; e_jra = iop; end
        default: begin e_jr = 1; e_jra = iop; e_fl = 1; end
      endcase
    end
    chk("stall", 32'(bus.stall), 32'(e_stall));
    chk("isBranch", 32'(bus.isBranch), 32'(e_br));
    chk("branchAddr", bus.branchAddr, e_ba);
    chk("isJump", 32'(bus.isJump), 32'(e_j));
    chk("jumpAddr", 32'(bus.jumpAddr), 32'(e_ja));
    chk("isJumpReg", 32'(bus.isJumpReg), 32'(e_jr));
    chk("jumpRegAddr", bus.jumpRegAddr, e_jra);
    chk("flush", 32'(bus.flush), 32'(e_fl));
    chk("redirectCount", bus.redirectCount, e_cnt);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.brReq = 0; bus.jReq = 0; bus.jrReq = 0; bus.eretReq = 0; bus.excReq = 0;
  endtask

  // {stallReq, excReq, eretReq, jrReq, jReq, brReq}
  localparam logic [5:0] VEC [16] = '{
    6'b000001, 6'b100010, 6'b100100, 6'b000000, 6'b010000, 6'b010000, 6'b001000, 6'b000000,
    6'b101000, 6'b000011, 6'b000000, 6'b010000, 6'b100110, 6'b000100, 6'b011000, 6'b000000
  };

  initial begin
    reset = 1;
    bus.stallReq = 0; bus.brOffset = 0; bus.jIndex = 0; bus.jrTarget = 0; bus.epc = 0;
    idle();
    cyc();
    chk("lit_reset_stall", 32'(bus.stall), 32'd0);
    chk("lit_reset_count", bus.redirectCount, 32'd0);
    cyc();
    reset = 0;

    // Taken branch, no stall
    bus.brReq = 1; bus.brOffset = -32'sd3;
    #1;
    chk("lit_br_is", 32'(bus.isBranch), 32'd1);
    chk("lit_br_addr", bus.branchAddr, 32'hFFFF_FFFD);
    chk("lit_br_stall", 32'(bus.stall), 32'd0);
    cyc(); idle();
    #1 chk("lit_br_count", bus.redirectCount, 32'd1);

    // Jump held through a 3-cycle stall; later jr ignored
    bus.stallReq = 1; bus.jReq = 1; bus.jIndex = 26'h0000C00;
    #1;
    chk("lit_j_c1_stall", 32'(bus.stall), 32'd1);
    chk("lit_j_c1_nojmp", 32'(bus.isJump), 32'd0);
    cyc(); idle();
    bus.jrReq = 1; bus.jrTarget = 32'h0000_2000;
    #1 chk("lit_j_c2_nojr", 32'(bus.isJumpReg), 32'd0);
    cyc(); idle();
    #1 chk("lit_j_c3_stall", 32'(bus.stall), 32'd1);
    cyc();
    bus.stallReq = 0;
    #1;
    chk("lit_j_c4_is", 32'(bus.isJump), 32'd1);
    chk("lit_j_c4_addr", 32'(bus.jumpAddr), 32'h0000C00);
    cyc();
    #1 chk("lit_j_count", bus.redirectCount, 32'd2);

    // jr beats br in the same cycle
    bus.jrReq = 1; bus.brReq = 1; bus.jrTarget = 32'h0000_3010; bus.brOffset = 32'd5;
    #1;
    chk("lit_jr_is", 32'(bus.isJumpReg), 32'd1);
    chk("lit_jr_addr", bus.jumpRegAddr, 32'h0000_3010);
    chk("lit_jr_nobr", 32'(bus.isBranch), 32'd0);
    cyc(); idle();

    // Pending branch discarded by an exception under stall
    bus.stallReq = 1; bus.brReq = 1; bus.brOffset = 32'd8;
    cyc(); idle();
    bus.excReq = 1;
    #1;
    chk("lit_exc_stall", 32'(bus.stall), 32'd0);
    chk("lit_exc_vec", bus.jumpRegAddr, 32'h0000_4180);
    chk("lit_exc_flush1", 32'(bus.flush), 32'd1);
    cyc(); idle();
    bus.jReq = 1; bus.jIndex = 26'h5;
    #1;
    chk("lit_exc_flush2", 32'(bus.flush), 32'd1);
    chk("lit_exc_noj", 32'(bus.isJump), 32'd0);
    cyc(); idle();
    bus.stallReq = 0;
    #1;
    chk("lit_exc_flush_end", 32'(bus.flush), 32'd0);
    chk("lit_exc_nobr", 32'(bus.isBranch), 32'd0);
    chk("lit_exc_count", bus.redirectCount, 32'd4);
    cyc();

    // eret: redirect plus one flush cycle
    bus.eretReq = 1; bus.epc = 32'h0000_3040;
    #1;
    chk("lit_eret_addr", bus.jumpRegAddr, 32'h0000_3040);
    chk("lit_eret_flush", 32'(bus.flush), 32'd1);
    cyc(); idle();
    #1 chk("lit_eret_flush_end", 32'(bus.flush), 32'd0);
    cyc();

    // Reset while a jump is pending
    bus.stallReq = 1; bus.jReq = 1; bus.jIndex = 26'h123;
    cyc(); idle();
    reset = 1;
    #1 chk("lit_rst_stall", 32'(bus.stall), 32'd0);
    cyc();
    reset = 0;
    cyc();
    bus.stallReq = 0;
    #1;
    chk("lit_rst_count", bus.redirectCount, 32'd0);
    chk("lit_rst_nojmp", 32'(bus.isJump), 32'd0);
    cyc(); cyc();

    // Mixed request table, including back-to-back exceptions
    for (int i = 0; i < 16; i++) begin
      {bus.stallReq, bus.excReq, bus.eretReq, bus.jrReq, bus.jReq, bus.brReq} = VEC[i];
      bus.brOffset = 32'(i * 4);
      bus.jIndex   = 26'(i + 100);
      bus.jrTarget = 32'h3000 + 32'(i);
      bus.epc      = 32'h5000 + 32'(i);
      cyc();
    end
    idle();
    bus.stallReq = 0;
    cyc(); cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
